// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// The HALT state only exists when MC_ILLEGAL_HALT_EN is defined.
package riscv_mc_pkg;

    localparam int MC_OP_W    = 7;
    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
`ifdef MC_ILLEGAL_HALT_EN
        JAL      = 4'd10,
        HALT     = 4'd11
`else
        JAL      = 4'd10
`endif
    } state_t;

    localparam logic [MC_OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [MC_OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [MC_OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [MC_OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [MC_OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [MC_OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic op_known(input logic [MC_OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle main FSM.
// With MC_ILLEGAL_HALT_EN an unknown opcode parks the FSM in HALT.
module mc_next_state
    import riscv_mc_pkg::*;
#(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state_next
);

    state_t nxt;

    always_comb begin
        nxt = FETCH;
        case (state_t'(state))
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) nxt = MEMADR;
                else if (op == OP_R)            nxt = EXECUTER;
                else if (op == OP_I)            nxt = EXECUTEI;
                else if (op == OP_BEQ)          nxt = BEQ;
                else if (op == OP_JAL)          nxt = JAL;
`ifdef MC_ILLEGAL_HALT_EN
                else                            nxt = HALT;
`else
                else                            nxt = FETCH;
`endif
            end
            MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    nxt = FETCH;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BEQ:      nxt = FETCH;
            JAL:      nxt = ALUWB;
`ifdef MC_ILLEGAL_HALT_EN
            HALT:     nxt = HALT;
`endif
            default:  nxt = FETCH;
        endcase
    end

    assign state_next = nxt;

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle RV32I core with a stallable memory request.
// Define MC_ILLEGAL_HALT_EN to halt on unknown opcodes instead of treating them as nops.
module mc_main_fsm
    import riscv_mc_pkg::*;
#(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_valid,
    output logic            pc_write,
    output logic            adr_src,
    output logic            ir_write,
    output logic            mem_write,
    output logic            reg_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            instr_done,
    output logic            illegal
);

    // Memory handshake: a request is open while mem_valid is high and completes
    // on the cycle mem_ready is high; the FSM holds its state until then.

    state_t             state;
    logic [STATE_W-1:0] state_next;
    logic               pc_update;
    logic               branch;

    mc_next_state #(
        .OP_W    (OP_W),
        .STATE_W (STATE_W)
    ) u_next (
        .state      (state),
        .op         (op),
        .mem_ready  (mem_ready),
        .state_next (state_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_t'(state_next);
    end

    always_comb begin
        mem_valid  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                // PC and IR only load on the completing cycle of the fetch.
                mem_valid  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
`ifndef MC_ILLEGAL_HALT_EN
                instr_done = !op_known(op);
`endif
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                mem_valid = 1'b1;
                adr_src   = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                mem_valid  = 1'b1;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef MC_ILLEGAL_HALT_EN
            HALT: illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

endmodule
